// File: rtl/sha2_k_sequencer.sv
// ============================================================================
//  Module      : sha2_k_sequencer
//  Description : Streams SHA-2 round constants K[0..ROUNDS-1] over valid/ready.
//                Optional in-stream restart enabled by SHA2_K_SEQ_RESTART_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha2_k_sequencer #(
    parameter int MODE   = 256,
    parameter int STEP_W = 7
) (
    input  wire logic                                clk_i,
    input  wire logic                                rst_i,
    input  wire logic                                start_i,
    input  wire logic                                abort_i,
    input  wire logic                                k_ready_i,
    output logic                                     k_valid_o,
    output logic [((MODE == 512) ? 64 : 32)-1:0]     k_o,
    output logic [STEP_W-1:0]                        step_o,
    output logic                                     last_o,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int WORD_W = (MODE == 512) ? 64 : 32;
    localparam int ROUNDS = (MODE == 512) ? 80 : 64;
    localparam logic [STEP_W-1:0] c_LAST_STEP = STEP_W'(ROUNDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_n;
    logic [WORD_W-1:0]   r_k;
    logic [WORD_W-1:0]   w_k_n;
    logic [WORD_W-1:0]   w_rom;
    logic                r_valid;
    logic                w_valid_n;
    logic                r_done;
    logic                w_done_n;
    logic                w_xfer;
    logic                w_at_last;
    logic                w_restart;

    assign w_xfer    = r_valid & k_ready_i;
    assign w_at_last = (r_step == c_LAST_STEP);

`ifdef SHA2_K_SEQ_RESTART_EN
    assign w_restart = start_i;
`else
    assign w_restart = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_step  <= w_step_n;
            r_k     <= w_k_n;
            r_valid <= w_valid_n;
            r_done  <= w_done_n;
        end
    end

    // Priority: abort, then restart, then transfer; stalls fall through to hold.
    always_comb begin
        w_state_n = r_state;
        w_step_n  = r_step;
        w_valid_n = r_valid;
        w_done_n  = 1'b0;
        if (abort_i) begin
            w_state_n = S_IDLE;
            w_step_n  = '0;
            w_valid_n = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_n = S_RUN;
                        w_step_n  = '0;
                        w_valid_n = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_restart) begin
                        w_step_n  = '0;
                        w_valid_n = 1'b1;
                    end else if (w_xfer) begin
                        if (w_at_last) begin
                            w_state_n = S_IDLE;
                            w_step_n  = '0;
                            w_valid_n = 1'b0;
                            w_done_n  = 1'b1;
                        end else begin
                            w_step_n = r_step + STEP_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                    w_step_n  = '0;
                    w_valid_n = 1'b0;
                end
            endcase
        end
    end

    // The ROM is addressed by the next step so k_o lands with step_o.
    assign w_k_n = w_valid_n ? w_rom : '0;

    generate
        if (MODE == 512) begin : g_rom512
            always_comb begin
                case (int'(w_step_n))
                    0:  w_rom = 64'h428a2f98d728ae22;
                    1:  w_rom = 64'h7137449123ef65cd;
                    2:  w_rom = 64'hb5c0fbcfec4d3b2f;
                    3:  w_rom = 64'he9b5dba58189dbbc;
                    4:  w_rom = 64'h3956c25bf348b538;
                    5:  w_rom = 64'h59f111f1b605d019;
                    6:  w_rom = 64'h923f82a4af194f9b;
                    7:  w_rom = 64'hab1c5ed5da6d8118;
                    8:  w_rom = 64'hd807aa98a3030242;
                    9:  w_rom = 64'h12835b0145706fbe;
                    10: w_rom = 64'h243185be4ee4b28c;
                    11: w_rom = 64'h550c7dc3d5ffb4e2;
                    12: w_rom = 64'h72be5d74f27b896f;
                    13: w_rom = 64'h80deb1fe3b1696b1;
                    14: w_rom = 64'h9bdc06a725c71235;
                    15: w_rom = 64'hc19bf174cf692694;
                    16: w_rom = 64'he49b69c19ef14ad2;
                    17: w_rom = 64'hefbe4786384f25e3;
                    18: w_rom = 64'h0fc19dc68b8cd5b5;
                    19: w_rom = 64'h240ca1cc77ac9c65;
                    20: w_rom = 64'h2de92c6f592b0275;
                    21: w_rom = 64'h4a7484aa6ea6e483;
                    22: w_rom = 64'h5cb0a9dcbd41fbd4;
                    23: w_rom = 64'h76f988da831153b5;
                    24: w_rom = 64'h983e5152ee66dfab;
                    25: w_rom = 64'ha831c66d2db43210;
                    26: w_rom = 64'hb00327c898fb213f;
                    27: w_rom = 64'hbf597fc7beef0ee4;
                    28: w_rom = 64'hc6e00bf33da88fc2;
                    29: w_rom = 64'hd5a79147930aa725;
                    30: w_rom = 64'h06ca6351e003826f;
                    31: w_rom = 64'h142929670a0e6e70;
                    32: w_rom = 64'h27b70a8546d22ffc;
                    33: w_rom = 64'h2e1b21385c26c926;
                    34: w_rom = 64'h4d2c6dfc5ac42aed;
                    35: w_rom = 64'h53380d139d95b3df;
                    36: w_rom = 64'h650a73548baf63de;
                    37: w_rom = 64'h766a0abb3c77b2a8;
                    38: w_rom = 64'h81c2c92e47edaee6;
                    39: w_rom = 64'h92722c851482353b;
                    40: w_rom = 64'ha2bfe8a14cf10364;
                    41: w_rom = 64'ha81a664bbc423001;
                    42: w_rom = 64'hc24b8b70d0f89791;
                    43: w_rom = 64'hc76c51a30654be30;
                    44: w_rom = 64'hd192e819d6ef5218;
                    45: w_rom = 64'hd69906245565a910;
                    46: w_rom = 64'hf40e35855771202a;
                    47: w_rom = 64'h106aa07032bbd1b8;
                    48: w_rom = 64'h19a4c116b8d2d0c8;
                    49: w_rom = 64'h1e376c085141ab53;
                    50: w_rom = 64'h2748774cdf8eeb99;
                    51: w_rom = 64'h34b0bcb5e19b48a8;
                    52: w_rom = 64'h391c0cb3c5c95a63;
                    53: w_rom = 64'h4ed8aa4ae3418acb;
                    54: w_rom = 64'h5b9cca4f7763e373;
                    55: w_rom = 64'h682e6ff3d6b2b8a3;
                    56: w_rom = 64'h748f82ee5defb2fc;
                    57: w_rom = 64'h78a5636f43172f60;
                    58: w_rom = 64'h84c87814a1f0ab72;
                    59: w_rom = 64'h8cc702081a6439ec;
                    60: w_rom = 64'h90befffa23631e28;
                    61: w_rom = 64'ha4506cebde82bde9;
                    62: w_rom = 64'hbef9a3f7b2c67915;
                    63: w_rom = 64'hc67178f2e372532b;
                    64: w_rom = 64'hca273eceea26619c;
                    65: w_rom = 64'hd186b8c721c0c207;
                    66: w_rom = 64'heada7dd6cde0eb1e;
                    67: w_rom = 64'hf57d4f7fee6ed178;
                    68: w_rom = 64'h06f067aa72176fba;
                    69: w_rom = 64'h0a637dc5a2c898a6;
                    70: w_rom = 64'h113f9804bef90dae;
                    71: w_rom = 64'h1b710b35131c471b;
                    72: w_rom = 64'h28db77f523047d84;
                    73: w_rom = 64'h32caab7b40c72493;
                    74: w_rom = 64'h3c9ebe0a15c9bebc;
                    75: w_rom = 64'h431d67c49c100d4c;
                    76: w_rom = 64'h4cc5d4becb3e42b6;
                    77: w_rom = 64'h597f299cfc657e2a;
                    78: w_rom = 64'h5fcb6fab3ad6faec;
                    79: w_rom = 64'h6c44198c4a475817;
                    default: w_rom = '0;
                endcase
            end
        end else begin : g_rom256
            always_comb begin
                case (int'(w_step_n))
                    0:  w_rom = 32'h428a2f98;
                    1:  w_rom = 32'h71374491;
                    2:  w_rom = 32'hb5c0fbcf;
                    3:  w_rom = 32'he9b5dba5;
                    4:  w_rom = 32'h3956c25b;
                    5:  w_rom = 32'h59f111f1;
                    6:  w_rom = 32'h923f82a4;
                    7:  w_rom = 32'hab1c5ed5;
                    8:  w_rom = 32'hd807aa98;
                    9:  w_rom = 32'h12835b01;
                    10: w_rom = 32'h243185be;
                    11: w_rom = 32'h550c7dc3;
                    12: w_rom = 32'h72be5d74;
                    13: w_rom = 32'h80deb1fe;
                    14: w_rom = 32'h9bdc06a7;
                    15: w_rom = 32'hc19bf174;
                    16: w_rom = 32'he49b69c1;
                    17: w_rom = 32'hefbe4786;
                    18: w_rom = 32'h0fc19dc6;
                    19: w_rom = 32'h240ca1cc;
                    20: w_rom = 32'h2de92c6f;
                    21: w_rom = 32'h4a7484aa;
                    22: w_rom = 32'h5cb0a9dc;
                    23: w_rom = 32'h76f988da;
                    24: w_rom = 32'h983e5152;
                    25: w_rom = 32'ha831c66d;
                    26: w_rom = 32'hb00327c8;
                    27: w_rom = 32'hbf597fc7;
                    28: w_rom = 32'hc6e00bf3;
                    29: w_rom = 32'hd5a79147;
                    30: w_rom = 32'h06ca6351;
                    31: w_rom = 32'h14292967;
                    32: w_rom = 32'h27b70a85;
                    33: w_rom = 32'h2e1b2138;
                    34: w_rom = 32'h4d2c6dfc;
                    35: w_rom = 32'h53380d13;
                    36: w_rom = 32'h650a7354;
                    37: w_rom = 32'h766a0abb;
                    38: w_rom = 32'h81c2c92e;
                    39: w_rom = 32'h92722c85;
                    40: w_rom = 32'ha2bfe8a1;
                    41: w_rom = 32'ha81a664b;
                    42: w_rom = 32'hc24b8b70;
                    43: w_rom = 32'hc76c51a3;
                    44: w_rom = 32'hd192e819;
                    45: w_rom = 32'hd6990624;
                    46: w_rom = 32'hf40e3585;
                    47: w_rom = 32'h106aa070;
                    48: w_rom = 32'h19a4c116;
                    49: w_rom = 32'h1e376c08;
                    50: w_rom = 32'h2748774c;
                    51: w_rom = 32'h34b0bcb5;
                    52: w_rom = 32'h391c0cb3;
                    53: w_rom = 32'h4ed8aa4a;
                    54: w_rom = 32'h5b9cca4f;
                    55: w_rom = 32'h682e6ff3;
                    56: w_rom = 32'h748f82ee;
                    57: w_rom = 32'h78a5636f;
                    58: w_rom = 32'h84c87814;
                    59: w_rom = 32'h8cc70208;
                    60: w_rom = 32'h90befffa;
                    61: w_rom = 32'ha4506ceb;
                    62: w_rom = 32'hbef9a3f7;
                    63: w_rom = 32'hc67178f2;
                    default: w_rom = '0;
                endcase
            end
        end
    endgenerate

    assign k_valid_o = r_valid;
    assign k_o       = r_k;
    assign step_o    = r_step;
    assign last_o    = r_valid & w_at_last;
    assign busy_o    = (r_state == S_RUN);
    assign done_o    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sha2_k_sequencer.sv
// ============================================================================
//  Module      : tb_sha2_k_sequencer
//  Description : Directed self-checking bench for sha2_k_sequencer (256 and 512).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha2_k_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_abort, a_ready;
    logic        a_valid, a_last, a_busy, a_done;
    logic [31:0] a_k;
    logic [6:0]  a_step;
    logic        b_start, b_abort, b_ready;
    logic        b_valid, b_last, b_busy, b_done;
    logic [63:0] b_k;
    logic [6:0]  b_step;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] K256 [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    always #5 clk = ~clk;

    sha2_k_sequencer #(.MODE(256), .STEP_W(7)) u_dut256 (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .abort_i(a_abort), .k_ready_i(a_ready),
        .k_valid_o(a_valid), .k_o(a_k), .step_o(a_step), .last_o(a_last), .busy_o(a_busy), .done_o(a_done)
    );

    sha2_k_sequencer #(.MODE(512), .STEP_W(7)) u_dut512 (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(b_abort), .k_ready_i(b_ready),
        .k_valid_o(b_valid), .k_o(b_k), .step_o(b_step), .last_o(b_last), .busy_o(b_busy), .done_o(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word_a(input int idx);
        chk("a_step", 64'(a_step), 64'(idx));
        chk("a_k", 64'(a_k), 64'(K256[idx]));
        chk("a_valid", 64'(a_valid), 64'd1);
    endtask

    task automatic start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic abort_a();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc;
        int exp_idx;
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_a_k", 64'(a_k), 64'd0);
        chk("rst_a_step", 64'(a_step), 64'd0);
        chk("rst_a_last", 64'(a_last), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_a_done", 64'(a_done), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_k", b_k, 64'd0);
        rst = 1'b0;
        tick();

        // Abort beats start in IDLE
        a_start = 1'b1; a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("abort_start_valid", 64'(a_valid), 64'd0);
        chk("abort_start_busy", 64'(a_busy), 64'd0);

        // Full-rate 256 stream (start still high from above)
        tick();
        a_start = 1'b0;
        chk_word_a(0);
        chk("s256_busy", 64'(a_busy), 64'd1);
        for (int i = 1; i < 64; i++) begin
            tick();
            chk_word_a(i);
            chk("s256_last", 64'(a_last), 64'(i == 63));
        end
        tick();
        chk("s256_done", 64'(a_done), 64'd1);
        chk("s256_end_valid", 64'(a_valid), 64'd0);
        chk("s256_end_busy", 64'(a_busy), 64'd0);
        chk("s256_end_k", 64'(a_k), 64'd0);
        chk("s256_end_step", 64'(a_step), 64'd0);
        chk("s256_end_last", 64'(a_last), 64'd0);
        tick();
        chk("s256_done_pulse", 64'(a_done), 64'd0);

        // 512 stream
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("s512_k0", b_k, 64'h428a2f98d728ae22);
        chk("s512_step0", 64'(b_step), 64'd0);
        for (int i = 1; i < 80; i++) begin
            tick();
            chk("s512_step", 64'(b_step), 64'(i));
            chk("s512_last", 64'(b_last), 64'(i == 79));
            if (i < 64) chk("s512_k_hi", 64'(b_k[63:32]), 64'(K256[i]));
            if (i == 1)  chk("s512_k1", b_k, 64'h7137449123ef65cd);
            if (i == 63) chk("s512_k63", b_k, 64'hc67178f2e372532b);
            if (i == 64) chk("s512_k64", b_k, 64'hca273eceea26619c);
            if (i == 79) chk("s512_k79", b_k, 64'h6c44198c4a475817);
        end
        tick();
        chk("s512_done", 64'(b_done), 64'd1);
        chk("s512_end_valid", 64'(b_valid), 64'd0);
        chk("s512_end_busy", 64'(b_busy), 64'd0);

        // Backpressure at step 5 for three cycles
        start_a();
        cyc = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cyc++;
        end
        chk_word_a(5);
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc++;
            chk_word_a(5);
        end
        a_ready = 1'b1;
        exp_idx = 5;
        while (!a_done && cyc < 200) begin
            tick();
            cyc++;
            if (!a_done) begin
                exp_idx++;
                chk_word_a(exp_idx);
            end
        end
        chk("bp_done_cycle", 64'(cyc), 64'd68);
        chk("bp_done", 64'(a_done), 64'd1);

        // Abort at step 10 together with start
        tick();
        start_a();
        for (int i = 0; i < 10; i++) tick();
        chk_word_a(10);
        a_abort = 1'b1; a_start = 1'b1;
        tick();
        a_abort = 1'b0; a_start = 1'b0;
        chk("abort_valid", 64'(a_valid), 64'd0);
        chk("abort_step", 64'(a_step), 64'd0);
        chk("abort_k", 64'(a_k), 64'd0);
        chk("abort_busy", 64'(a_busy), 64'd0);
        chk("abort_done", 64'(a_done), 64'd0);
        tick();
        chk("abort_idle_valid", 64'(a_valid), 64'd0);
        chk("abort_idle_done", 64'(a_done), 64'd0);
        start_a();
        chk_word_a(0);
        abort_a();

        // Reset mid-stream at step 30
        start_a();
        for (int i = 0; i < 30; i++) tick();
        chk_word_a(30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", 64'(a_valid), 64'd0);
        chk("mrst_k", 64'(a_k), 64'd0);
        chk("mrst_step", 64'(a_step), 64'd0);
        chk("mrst_last", 64'(a_last), 64'd0);
        chk("mrst_busy", 64'(a_busy), 64'd0);
        chk("mrst_done", 64'(a_done), 64'd0);
        start_a();
        chk_word_a(0);
        abort_a();

        // Start on the final word
        start_a();
        for (int i = 0; i < 63; i++) tick();
        chk_word_a(63);
        chk("fin_last", 64'(a_last), 64'd1);
        a_start = 1'b1;
        tick();
`ifdef SHA2_K_SEQ_RESTART_EN
        a_start = 1'b0;
        chk_word_a(0);
        chk("rs_done", 64'(a_done), 64'd0);
        chk("rs_busy", 64'(a_busy), 64'd1);
`else
        chk("fin_done", 64'(a_done), 64'd1);
        chk("fin_valid", 64'(a_valid), 64'd0);
        tick();
        a_start = 1'b0;
        chk_word_a(0);
        chk("restart_done", 64'(a_done), 64'd0);
        tick();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk_word_a(2);
`endif
        abort_a();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
